hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 3, number of tracked post-decode stages (index 0 = EX, STAGES-1 = WB); legal range 2..8.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, register address width.
REQ-003 SHALL have parameter CNT_W, default 16, performance counter width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 id_valid  input  1  decode stage holds a valid instruction.
REQ-007 id_rs1, id_rs2  input  REG_ADDR_W each  decode source register addresses.
REQ-008 id_rs1_v, id_rs2_v  input  1 each  source register is actually read.
REQ-009 id_rd  input  REG_ADDR_W  decode destination register.
REQ-010 id_rd_we  input  1  decode instruction writes id_rd.
REQ-011 id_is_load  input  1  decode instruction is a load.
REQ-012 br_taken  input  1  EX-stage instruction resolved a taken branch/jump this cycle.
REQ-013 stall_out  output  1  hold PC and IF/ID register; combinational.
REQ-014 flush_out  output  1  squash IF/ID contents; combinational.
REQ-015 stage_valid  output  STAGES  valid bit per tracked stage, registered.
REQ-016 stall_cycles, flush_count  output  CNT_W each  saturating performance counters.

Function
REQ-017 SHALL keep a tracking entry per stage: {valid, rd, rd_we, is_load}.
REQ-018 Each cycle entries SHALL shift k -> k+1; entry STAGES-1 retires.
REQ-019 Entry 0 SHALL load the decode instruction when id_valid=1, stall_out=0, flush_out=0; otherwise SHALL load a bubble (valid=0).
REQ-020 A source SHALL match entry k when the source is valid, entry k is valid with rd_we=1, rd equals the source address, and rd is nonzero.
REQ-021 Matches in stage STAGES-1 (WB) SHALL never stall; the register file bypasses same-cycle writes.
REQ-022 flush_out SHALL equal br_taken.
REQ-023 When br_taken=1, stall_out SHALL be 0 regardless of hazards; branch wins over stall.
REQ-024 stall_out SHALL be 0 whenever id_valid=0.
REQ-025 stall_cycles SHALL increment on each cycle with stall_out=1; flush_count SHALL increment on each cycle with flush_out=1; both saturate at 2^CNT_W-1 and do not wrap.
REQ-026 An entry with rd=0 SHALL travel normally but never cause a match.

Reset
REQ-027 While rst_n=0, all entries SHALL be invalid, stage_valid=0, and both counters 0.
REQ-028 stall_out and flush_out SHALL be 0 during reset.
REQ-029 Reset asserted mid-stall or mid-flush SHALL drop all in-flight tracking immediately; the first cycle after release SHALL see an empty pipeline.

Configuration
REQ-030 Macro HAZARD_FORWARDING_EN SHALL select the hazard policy.
REQ-031 Without the macro: stall_out=1 on any match in stages 0..STAGES-2.
REQ-032 With the macro: stall_out=1 only on a match in stage 0 whose entry has is_load=1 (load-use).
REQ-033 With the macro, outputs fwd_sel_rs1 and fwd_sel_rs2 (width clog2(STAGES+1)) SHALL be present:
- value 0: use register file;
- value k+1: forward from stage k;
- the youngest (lowest k) match SHALL win;
- value 0 while stall_out=1.

Verification (STAGES=3)
REQ-034 Decode x5<-...; next cycle decode reads rs1=x5, no forwarding -> stall_out=1 for 2 cycles, then 0; stall_cycles=2.
REQ-035 Same sequence with HAZARD_FORWARDING_EN, non-load producer -> stall_out=0 and fwd_sel_rs1=1; one cycle later a reader sees fwd_sel_rs1=2.
REQ-036 Load to x7 followed by a reader of x7, with forwarding -> exactly 1 stall cycle, then fwd_sel_rs1=2.
REQ-037 br_taken=1 while decode holds a hazard -> flush_out=1, stall_out=0, entry 0 bubble, flush_count=1.
REQ-038 Producer writes x0, then a reader of x0 -> no stall, fwd_sel=0.
REQ-039 Force CNT_W=2 and 5 stall cycles -> stall_cycles holds 3; rst_n pulsed low mid-stall -> stage_valid=000, counters 0, stall_out=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard detector and flush controller.
// Tracks the destination register of every in-flight instruction past decode.
// It stalls decode on a read-after-write hazard and flushes decode on a taken
// branch. It also keeps saturating stall and flush counters.
// Optional build macro HAZARD_FORWARDING_EN switches the design to a
// forwarding policy. With the macro, only a load-use hazard stalls, and the
// fwd_sel_rs1/fwd_sel_rs2 bypass selects are added as outputs.
module hazard_ctrl #(
  parameter int STAGES     = 3,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_v,
  input  logic                  id_rs2_v,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_we,
  input  logic                  id_is_load,
  input  logic                  br_taken,
  output logic                  stall_out,
  output logic                  flush_out,
  output logic [STAGES-1:0]     stage_valid,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
`ifdef HAZARD_FORWARDING_EN
  ,
  output logic [$clog2(STAGES+1)-1:0] fwd_sel_rs1,
  output logic [$clog2(STAGES+1)-1:0] fwd_sel_rs2
`endif
);

  localparam int FWD_W = $clog2(STAGES+1);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_we;
    logic                  is_load;
  } entry_t;

  // pipe[0] is EX; pipe[STAGES-1] is WB.
  entry_t            pipe [STAGES];
  logic [STAGES-1:0] rs1_hit;
  logic [STAGES-1:0] rs2_hit;
  logic              hazard;

  // Compare each decode source against every tracked destination register.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so that no path leaves it unassigned and no latch is inferred.
    rs1_hit = '0;
    rs2_hit = '0;
    for (int k = 0; k < STAGES; k++) begin
      rs1_hit[k] = id_rs1_v && pipe[k].valid && pipe[k].rd_we &&
                   (pipe[k].rd == id_rs1) && (pipe[k].rd != '0);
      rs2_hit[k] = id_rs2_v && pipe[k].valid && pipe[k].rd_we &&
                   (pipe[k].rd == id_rs2) && (pipe[k].rd != '0);
    end
  end

  // Hazard policy. WB matches never stall because the register file bypasses them.
  always_comb begin
`ifdef HAZARD_FORWARDING_EN
    hazard = (rs1_hit[0] || rs2_hit[0]) && pipe[0].is_load;
`else
    hazard = (|rs1_hit[STAGES-2:0]) || (|rs2_hit[STAGES-2:0]);
`endif
  end

  // A branch overrides a stall. Both outputs stay quiet while reset is held.
  always_comb begin
    flush_out = rst_n && br_taken;
    stall_out = rst_n && id_valid && !br_taken && hazard;
  end

`ifdef HAZARD_FORWARDING_EN
  // Bypass select. The scan runs oldest to youngest, so the youngest match wins.
  always_comb begin
    fwd_sel_rs1 = '0;
    fwd_sel_rs2 = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      if (rs1_hit[k]) fwd_sel_rs1 = FWD_W'(k + 1);
      if (rs2_hit[k]) fwd_sel_rs2 = FWD_W'(k + 1);
    end
    if (stall_out) begin
      fwd_sel_rs1 = '0;
      fwd_sel_rs2 = '0;
    end
  end
`endif

  // Per-stage valid bits, exported for observation.
  always_comb begin
    stage_valid = '0;
    for (int k = 0; k < STAGES; k++) stage_valid[k] = pipe[k].valid;
  end

  // Advance the tracking pipe. A stall or flush inserts a bubble into EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the tracking array is reset in full. A stale valid bit would raise a false hazard right after reset.
      for (int k = 0; k < STAGES; k++) pipe[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the old value of its neighbour, which is how the shift works.
      for (int k = STAGES-1; k > 0; k--) pipe[k] <= pipe[k-1];
      if (id_valid && !stall_out && !flush_out)
        pipe[0] <= '{valid: 1'b1, rd: id_rd, rd_we: id_rd_we, is_load: id_is_load};
      else
        pipe[0] <= '0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_out && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (flush_out && flush_count  != '1) flush_count  <= flush_count  + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized self-checking bench for hazard_ctrl.
// A reference model keeps a queue of the most recent issue slots, youngest
// first, and derives the expected outputs from the hazard rules.
// Decode inputs are held while the model predicts a stall, as a real IF/ID
// register would hold them.
module tb_hazard_ctrl;

  localparam int STAGES = 3;
  localparam int RW     = 5;
  localparam int CNT_W  = 3;
  localparam int FWD_W  = $clog2(STAGES+1);
  localparam int N_CYC  = 4000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              id_valid = 1'b0;
  logic [RW-1:0]     id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic              id_rs1_v = 1'b0, id_rs2_v = 1'b0, id_rd_we = 1'b0, id_is_load = 1'b0;
  logic              br_taken = 1'b0;
  logic              stall_out, flush_out;
  logic [STAGES-1:0] stage_valid;
  logic [CNT_W-1:0]  stall_cycles, flush_count;
`ifdef HAZARD_FORWARDING_EN
  logic [FWD_W-1:0]  fwd_sel_rs1, fwd_sel_rs2;
`endif

  hazard_ctrl #(.STAGES(STAGES), .REG_ADDR_W(RW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_v(id_rs1_v), .id_rs2_v(id_rs2_v),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .br_taken(br_taken), .stall_out(stall_out), .flush_out(flush_out),
    .stage_valid(stage_valid), .stall_cycles(stall_cycles), .flush_count(flush_count)
`ifdef HAZARD_FORWARDING_EN
    , .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    int rd;
    bit we;
    bit ld;
  } slot_t;

  slot_t q[$];
  int    m_stalls, m_flushes;
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    slot_t b;
    b = '{valid: 0, rd: 0, we: 0, ld: 0};
    q.delete();
    for (int i = 0; i < STAGES; i++) q.push_back(b);
    m_stalls = 0;
    m_flushes = 0;
  endfunction

  // True when issue slot `age` (0 = EX) produces register src for a source that is read.
  function automatic bit produces(int age, int src, bit used);
    return used && q[age].valid && q[age].we && q[age].rd == src && src != 0;
  endfunction

  // Youngest producer of src, encoded as age+1, or 0 when there is none.
  function automatic int youngest(int src, bit used);
    for (int a = 0; a < STAGES; a++)
      if (produces(a, src, used)) return a + 1;
    return 0;
  endfunction

  function automatic bit model_stall();
    bit haz = 0;
`ifdef HAZARD_FORWARDING_EN
    haz = q[0].ld && (produces(0, int'(id_rs1), id_rs1_v) || produces(0, int'(id_rs2), id_rs2_v));
`else
    for (int a = 0; a < STAGES - 1; a++)
      if (produces(a, int'(id_rs1), id_rs1_v) || produces(a, int'(id_rs2), id_rs2_v)) haz = 1;
`endif
    return id_valid && !br_taken && haz;
  endfunction

  function automatic int sat_inc(int v);
    return (v == (1 << CNT_W) - 1) ? v : v + 1;
  endfunction

  function automatic int valid_mask();
    int m = 0;
    for (int a = 0; a < STAGES; a++) if (q[a].valid) m |= (1 << a);
    return m;
  endfunction

  initial begin
    bit exp_stall;
    bit hold;
    slot_t s;
    model_clear();
    hold = 0;
    // Inputs are active while reset is held; every output must stay zero.
    id_valid = 1; id_rs1 = 5; id_rs1_v = 1; br_taken = 1;
    #3;
    check("rst_stall", 32'(stall_out), 0);
    check("rst_flush", 32'(flush_out), 0);
    check("rst_valid", 32'(stage_valid), 0);
    check("rst_scnt",  32'(stall_cycles), 0);
    check("rst_fcnt",  32'(flush_count), 0);

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      if (cyc > 0 && $urandom_range(59) == 0) begin
        // Reset arriving mid-operation drops all in-flight state immediately.
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", 32'(stall_out), 0);
        check("mid_rst_flush", 32'(flush_out), 0);
        check("mid_rst_valid", 32'(stage_valid), 0);
        check("mid_rst_scnt",  32'(stall_cycles), 0);
        check("mid_rst_fcnt",  32'(flush_count), 0);
        model_clear();
        hold = 0;
        continue;
      end
      rst_n = 1'b1;
      if (!hold) begin
        id_valid   = ($urandom_range(3) != 0);
        id_rs1     = RW'($urandom_range(3));
        id_rs2     = RW'($urandom_range(3));
        id_rs1_v   = $urandom_range(1);
        id_rs2_v   = $urandom_range(1);
        id_rd      = RW'($urandom_range(3));
        id_rd_we   = ($urandom_range(3) != 0);
        id_is_load = $urandom_range(1);
      end
      br_taken = ($urandom_range(7) == 0);
      #1;
      exp_stall = model_stall();
      check("stall", 32'(stall_out), 32'(exp_stall));
      check("flush", 32'(flush_out), 32'(br_taken));
      check("stage_valid", 32'(stage_valid), 32'(valid_mask()));
      check("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
      check("flush_count", 32'(flush_count), 32'(m_flushes));
`ifdef HAZARD_FORWARDING_EN
      check("fwd_rs1", 32'(fwd_sel_rs1), exp_stall ? 0 : 32'(youngest(int'(id_rs1), id_rs1_v)));
      check("fwd_rs2", 32'(fwd_sel_rs2), exp_stall ? 0 : 32'(youngest(int'(id_rs2), id_rs2_v)));
`endif
      // Work out what the next rising edge does.
      if (exp_stall) m_stalls = sat_inc(m_stalls);
      if (br_taken)  m_flushes = sat_inc(m_flushes);
      s = '{valid: id_valid && !exp_stall && !br_taken, rd: int'(id_rd), we: id_rd_we, ld: id_is_load};
      q.push_front(s);
      void'(q.pop_back());
      hold = exp_stall;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
